// File: rtl/demux2_resp_bridge_if.sv
// Bundle of the grant, downstream-response, routed-response and status
// signals exchanged between the request bridge, the response bridge and
// the response consumer.
interface demux2_resp_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 20,
    parameter int AUX_WIDTH  = 6,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);
    logic                  data_gnt_CH0_i;
    logic                  data_gnt_CH1_i;
    logic                  data_r_valid_i;
    logic [DATA_WIDTH-1:0] data_r_rdata_i;
    logic [ID_WIDTH-1:0]   data_r_ID_i;
    logic [AUX_WIDTH-1:0]  data_r_aux_i;
    logic                  data_r_opc_i;
    logic                  data_r_valid_CH0_o;
    logic                  data_r_valid_CH1_o;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic [ID_WIDTH-1:0]   data_r_ID_o;
    logic [AUX_WIDTH-1:0]  data_r_aux_o;
    logic                  data_r_opc_o;
    logic                  stall_o;
    logic [CNT_WIDTH-1:0]  outstanding_o;
    logic                  err_o;

    // Bridge side: consumes grants and downstream responses.
    modport slave (
        input  data_gnt_CH0_i, data_gnt_CH1_i,
        input  data_r_valid_i, data_r_rdata_i, data_r_ID_i, data_r_aux_i, data_r_opc_i,
        output data_r_valid_CH0_o, data_r_valid_CH1_o,
        output data_r_rdata_o, data_r_ID_o, data_r_aux_o, data_r_opc_o,
        output stall_o, outstanding_o, err_o
    );

    // Environment side: produces grants and downstream responses.
    modport master (
        output data_gnt_CH0_i, data_gnt_CH1_i,
        output data_r_valid_i, data_r_rdata_i, data_r_ID_i, data_r_aux_i, data_r_opc_i,
        input  data_r_valid_CH0_o, data_r_valid_CH1_o,
        input  data_r_rdata_o, data_r_ID_o, data_r_aux_o, data_r_opc_o,
        input  stall_o, outstanding_o, err_o
    );
endinterface

// File: rtl/demux2_resp_bridge.sv
// Response-path companion of the 2:1 round-robin request bridge: remembers
// which channel won each grant and steers the in-order response stream back
// to that channel one registered cycle later.
module demux2_resp_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 20,
    parameter int AUX_WIDTH  = 6,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input logic                  clk,
    input logic                  rst,
    demux2_resp_bridge_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DEPTH-1:0]      tag_q;      // 0 = CH0, 1 = CH1
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CNT_WIDTH-1:0]  occ_q;
    logic                  valid_ch0_q;
    logic                  valid_ch1_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [AUX_WIDTH-1:0]  aux_q;
    logic                  opc_q;
    logic                  err_q;

    logic full;
    logic empty;
    logic gnt_one;
    logic gnt_both;
    logic pop;
    logic push;
    logic err_set;

    // Push/pop qualification and error detection for the current cycle.
    always_comb begin
        full     = (occ_q == CNT_FULL);
        empty    = (occ_q == '0);
        gnt_one  = bus.data_gnt_CH0_i ^ bus.data_gnt_CH1_i;
        gnt_both = bus.data_gnt_CH0_i & bus.data_gnt_CH1_i;
        pop      = bus.data_r_valid_i & ~empty;
        // A same-cycle pop frees the slot the push needs, so full only blocks without one.
        push     = gnt_one & (~full | pop);
        err_set  = gnt_both
                 | (gnt_one & full & ~pop)
                 | (bus.data_r_valid_i & empty);
    end

    // Tag FIFO, occupancy counter, routed response registers and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            valid_ch0_q <= 1'b0;
            valid_ch1_q <= 1'b0;
            rdata_q     <= '0;
            id_q        <= '0;
            aux_q       <= '0;
            opc_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= bus.data_gnt_CH1_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                rdata_q  <= bus.data_r_rdata_i;
                id_q     <= bus.data_r_ID_i;
                aux_q    <= bus.data_r_aux_i;
                opc_q    <= bus.data_r_opc_i;
            end
            valid_ch0_q <= pop & ~tag_q[rd_ptr_q];
            valid_ch1_q <= pop &  tag_q[rd_ptr_q];
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CNT_ONE;
                2'b01:   occ_q <= occ_q - CNT_ONE;
                default: occ_q <= occ_q;
            endcase
            err_q <= err_q | err_set;
        end
    end

    assign bus.data_r_valid_CH0_o = valid_ch0_q;
    assign bus.data_r_valid_CH1_o = valid_ch1_q;
    assign bus.data_r_rdata_o     = rdata_q;
    assign bus.data_r_ID_o        = id_q;
    assign bus.data_r_aux_o       = aux_q;
    assign bus.data_r_opc_o       = opc_q;
    assign bus.stall_o            = full & ~bus.data_r_valid_i;
    assign bus.outstanding_o      = occ_q;
    assign bus.err_o              = err_q;
endmodule

// File: tb/tb_demux2_resp_bridge.sv
// Self-checking bench for demux2_resp_bridge: directed scenarios plus random
// traffic, compared against a queue-based model of grant/response ordering.
module tb_demux2_resp_bridge;
    localparam int DW    = 32;
    localparam int IW    = 20;
    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux2_resp_bridge_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .AUX_WIDTH(AW),
                            .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    demux2_resp_bridge #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .AUX_WIDTH(AW),
                         .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding grant owners in order, plus expected outputs.
    bit            mq[$];
    bit            m_err;
    bit            m_v0, m_v1;
    logic [DW-1:0] m_rdata;
    logic [IW-1:0] m_id;
    logic [AW-1:0] m_aux;
    logic          m_opc;
    int            max_occ;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 0; m_v0 = 0; m_v1 = 0;
        m_rdata = '0; m_id = '0; m_aux = '0; m_opc = 1'b0;
    endtask

    task automatic check_outputs();
        check("valid_CH0",   64'(bus.data_r_valid_CH0_o), 64'(m_v0));
        check("valid_CH1",   64'(bus.data_r_valid_CH1_o), 64'(m_v1));
        check("rdata",       64'(bus.data_r_rdata_o),     64'(m_rdata));
        check("ID",          64'(bus.data_r_ID_o),        64'(m_id));
        check("aux",         64'(bus.data_r_aux_o),       64'(m_aux));
        check("opc",         64'(bus.data_r_opc_o),       64'(m_opc));
        check("outstanding", 64'(bus.outstanding_o),      64'(mq.size()));
        check("err",         64'(bus.err_o),              64'(m_err));
    endtask

    // One clock of stimulus: drive, check stall, advance model, check outputs.
    task automatic step(input logic g0, input logic g1, input logic rv,
                        input logic [DW-1:0] d, input logic [IW-1:0] id);
        logic [AW-1:0] aux;
        logic          opc;
        bit            t;
        aux = AW'($urandom);
        opc = 1'($urandom);
        bus.data_gnt_CH0_i = g0;
        bus.data_gnt_CH1_i = g1;
        bus.data_r_valid_i = rv;
        bus.data_r_rdata_i = d;
        bus.data_r_ID_i    = id;
        bus.data_r_aux_i   = aux;
        bus.data_r_opc_i   = opc;
        #1;
        check("stall", 64'(bus.stall_o), 64'(mq.size() == DEPTH && !rv));
        m_v0 = 0; m_v1 = 0;
        if (rv) begin
            if (mq.size() == 0) m_err = 1;
            else begin
                t = mq.pop_front();
                m_v0 = !t; m_v1 = t;
                m_rdata = d; m_id = id; m_aux = aux; m_opc = opc;
            end
        end
        if (g0 && g1) m_err = 1;
        else if (g0 || g1) begin
            if (mq.size() < DEPTH) mq.push_back(g1);
            else m_err = 1;
        end
        if (mq.size() > max_occ) max_occ = mq.size();
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, DW'($urandom), IW'($urandom));
    endtask

    task automatic do_reset();
        bus.data_gnt_CH0_i = 0; bus.data_gnt_CH1_i = 0; bus.data_r_valid_i = 0;
        bus.data_r_rdata_i = '0; bus.data_r_ID_i = '0; bus.data_r_aux_i = '0;
        bus.data_r_opc_i = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        check_outputs();
        check("stall_rst", 64'(bus.stall_o), 64'(0));
    endtask

    initial begin
        int g;
        bit rv;
        rst = 1;
        model_reset();
        do_reset();

        // Single transaction to CH1 with a three-cycle response delay.
        step(0, 1, 0, '0, '0);
        check("single_occ1", 64'(bus.outstanding_o), 64'(1));
        idle(); idle();
        step(0, 0, 1, 32'hDEADBEEF, 20'h5);
        check("single_v1",    64'(bus.data_r_valid_CH1_o), 64'(1));
        check("single_rdata", 64'(bus.data_r_rdata_o),     64'(32'hDEADBEEF));
        check("single_occ0",  64'(bus.outstanding_o),      64'(0));

        // Alternating grants, then back-to-back responses 1..4.
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, DW'(i), IW'(i));
            check("alt_v0", 64'(bus.data_r_valid_CH0_o), 64'(i % 2));
        end

        // Fill with CH0, observe stall, then pop+push in the same cycle.
        for (int i = 0; i < 4; i++) step(1, 0, 0, '0, '0);
        check("full_occ", 64'(bus.outstanding_o), 64'(4));
        idle();
        step(0, 1, 1, 32'hA5A5_0001, 20'h11);
        check("full_pop_v0", 64'(bus.data_r_valid_CH0_o), 64'(1));
        check("full_occ_kept", 64'(bus.outstanding_o), 64'(4));
        for (int i = 0; i < 4; i++) step(0, 0, 1, DW'($urandom), IW'($urandom));
        check("tail_is_CH1", 64'(bus.data_r_valid_CH1_o), 64'(1));

        // Overlapping push/pop across pointer wrap.
        max_occ = 0;
        step(1, 0, 0, '0, '0);
        for (int i = 1; i < 10; i++)
            step(i % 2 == 0, i % 2 == 1, 1, DW'(100 + i), IW'(i));
        step(0, 0, 1, DW'(110), IW'(10));
        check("wrap_maxocc", 64'(max_occ), 64'(1));
        check("wrap_err", 64'(bus.err_o), 64'(0));

        // Random legal traffic.
        for (int i = 0; i < 300; i++) begin
            g  = $urandom_range(0, 2);
            rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            if (mq.size() == DEPTH && !rv) g = 0;
            step(g == 1, g == 2, rv, DW'($urandom), IW'($urandom));
        end
        check("rand_err", 64'(bus.err_o), 64'(0));
        while (mq.size() > 0) step(0, 0, 1, DW'($urandom), IW'($urandom));

        // Protocol errors and stickiness.
        step(0, 0, 1, 32'h1234, 20'h1);
        check("empty_pop_err", 64'(bus.err_o), 64'(1));
        do_reset();
        step(1, 1, 0, '0, '0);
        check("both_gnt_occ", 64'(bus.outstanding_o), 64'(0));
        check("both_gnt_err", 64'(bus.err_o), 64'(1));
        for (int i = 0; i < 100; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), IW'($urandom));
        check("err_sticky", 64'(bus.err_o), 64'(1));

        // Reset with three outstanding, then a stale response.
        do_reset();
        while (mq.size() > 0) step(0, 0, 1, DW'($urandom), IW'($urandom));
        for (int i = 0; i < 3; i++) step(i == 1, i != 1, 0, '0, '0);
        check("pre_rst_occ", 64'(bus.outstanding_o), 64'(3));
        do_reset();
        step(0, 0, 1, 32'hCAFE, 20'h7);
        check("stale_v0", 64'(bus.data_r_valid_CH0_o), 64'(0));
        check("stale_err", 64'(bus.err_o), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
